dm_store_controller: RTL and testbench
======================================

Name: dm_store_controller

Overview:
MEM-stage store path between the pipeline interconnection_struct and the Data Memory write port. It aligns store data to the 64-bit memory lane, generates byte enables and detects misaligned stores. Accepted stores are buffered in a small FIFO store buffer and drained to Data Memory over a valid/ready handshake. It flags loads that overlap a still-buffered store, so the pipeline can hold the load until the store drains.

Parameters:
DEPTH, 4, store-buffer entries; power of 2, >= 2
ADDR_W, 64, width of i_struct.mem_addr and o_dm_wr_addr

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
i_struct  in  interconnection_struct  MEM-stage request; uses is_valid, mem_wr, mem_rd, mem_req_unit (`B/`HW/`W/`DW), mem_addr, mem_data
o_struct  out  interconnection_struct  i_struct passed through unchanged, combinational
o_stall  out  1  valid aligned store cannot be accepted this cycle
o_miss_aligned_error  out  1  misaligned store, combinational
o_load_hazard  out  1  valid load overlaps a buffered store
o_dm_wr_valid  out  1  head entry presented to Data Memory
i_dm_wr_ready  in  1  Data Memory accepts head entry
o_dm_wr_addr  out  ADDR_W  doubleword address, bits [2:0] = 0
o_dm_wr_data  out  64  lane-aligned write data
o_dm_wr_be  out  8  byte enables
o_sb_empty  out  1  buffer empty
o_sb_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Store request: i_struct.is_valid && i_struct.mem_wr. Let off = mem_addr[2:0].
- Lane alignment:
  - `B: be = 8'h01<<off; data byte lane off = mem_data[7:0].
  - `HW: be = 8'h03<<off; data = mem_data[15:0] placed at bit 8*off.
  - `W: be = 8'h0F<<off; data = mem_data[31:0] placed at bit 8*off.
  - `DW: be = 8'hFF; data = mem_data[63:0].
  - Bytes outside be are 0.
- Misalignment:
  - `HW with off[0]!=0, `W with off[1:0]!=0, `DW with off!=0.
  - Effect: o_miss_aligned_error=1, nothing enqueued, o_stall=0.
- Unknown mem_req_unit: nothing enqueued, no error, no stall.
- Push and pop:
  - push = aligned valid store && (count<DEPTH || pop).
  - pop = o_dm_wr_valid && i_dm_wr_ready.
- Stall: o_stall = aligned valid store && count==DEPTH && !pop. A stalled store is not enqueued; the pipeline re-presents it.
- Latency: a pushed entry appears at the head no earlier than the next cycle. With an empty buffer, o_dm_wr_valid rises the cycle after push.
- Ordering: FIFO; stores drain in acceptance order. Read/write pointers wrap modulo DEPTH.
- Count update: push&&pop leaves count unchanged; push only +1; pop only -1. Count never exceeds DEPTH and never underflows.
- Handshake:
  - o_dm_wr_valid = !empty.
  - o_dm_wr_addr/data/be are driven from the head entry and are stable while valid && !ready.
  - valid never drops without a pop.
  - When empty, o_dm_wr_addr/data/be = 0.
- Load hazard: o_load_hazard=1 when i_struct.is_valid && mem_rd && some occupied entry has addr[ADDR_W-1:3] == mem_addr[ADDR_W-1:3] and (entry be & load be) != 0. Load be is computed with the same alignment table. An entry popping this cycle still counts.
- Passthrough: o_struct = i_struct always; this block never modifies mem_data.
- Reset (rst_n=0 at clk edge):
  - Pointers, count and all entries clear.
  - o_dm_wr_valid=0, o_dm_wr_addr/data/be=0, o_sb_empty=1, o_sb_count=0.
  - Reset mid-drain discards all buffered stores.
  - Combinational outputs follow inputs with an empty buffer.

Test Plan:
- `W store, addr 0x1004, data 0xDEADBEEF, ready=1 -> next cycle o_dm_wr_valid=1, addr 0x1000, be 8'hF0, data 0xDEADBEEF_00000000; popped that cycle, o_sb_empty=1 after.
- `HW store at addr 0x1003 -> o_miss_aligned_error=1, o_stall=0, o_sb_count stays 0; `B at 0x1003, data 0xAB -> be 8'h08, data 0x00000000_AB000000.
- ready=0, five `DW stores at 0x0,0x8,0x10,0x18,0x20 with DEPTH=4 -> count 4; fifth store gives o_stall=1. Raise ready -> stall drops in that cycle and the fifth is accepted. Drain order 0x0..0x20, addr/data stable while ready=0.
- ready=0, buffered `B store to 0x2001; `W load at 0x2000 -> o_load_hazard=1; `W load at 0x2004 -> 0; `DW load at 0x3000 -> 0.
- Full buffer with ready=1 and new store in the same cycle -> push and pop together, count stays 4, o_stall=0.
- rst_n=0 for one edge with 3 entries buffered and ready=0 -> o_dm_wr_valid=0, o_sb_count=0, o_sb_empty=1, and no further writes appear after ready rises.

Source files
------------

// File: rtl/dm_store_controller.sv
// MEM-stage store path: aligns store data to the 64-bit Data Memory lane,
// builds byte enables, rejects misaligned stores, buffers accepted stores in
// a small FIFO and drains them to Data Memory over a valid/ready handshake.
// Loads that overlap a buffered store are flagged so the pipeline can hold them.

package dm_store_pkg;
  // Access-size encodings carried in mem_req_unit; other codes are unknown.
  localparam logic [2:0] UNIT_B  = 3'd0;
  localparam logic [2:0] UNIT_HW = 3'd1;
  localparam logic [2:0] UNIT_W  = 3'd2;
  localparam logic [2:0] UNIT_DW = 3'd3;

  typedef struct packed {
    logic        is_valid;
    logic        mem_wr;
    logic        mem_rd;
    logic [2:0]  mem_req_unit;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
  } interconnection_struct;
endpackage

`ifndef B
`define B  3'd0
`endif
`ifndef HW
`define HW 3'd1
`endif
`ifndef W
`define W  3'd2
`endif
`ifndef DW
`define DW 3'd3
`endif

module dm_store_controller
  import dm_store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  interconnection_struct      i_struct,
  output interconnection_struct      o_struct,
  output logic                       o_stall,
  output logic                       o_miss_aligned_error,
  output logic                       o_load_hazard,
  output logic                       o_dm_wr_valid,
  input  logic                       i_dm_wr_ready,
  output logic [ADDR_W-1:0]          o_dm_wr_addr,
  output logic [63:0]                o_dm_wr_data,
  output logic [7:0]                 o_dm_wr_be,
  output logic                       o_sb_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: o_dm_wr_valid is high whenever the buffer holds an entry; the
  // head entry transfers on a rising clk edge where valid && ready. Address,
  // data and byte enables stay fixed until that transfer, and valid only
  // falls after a transfer (or reset).

  // Byte-enable pattern for an access of the given size at byte offset off.
  function automatic logic [7:0] lane_be(input logic [2:0] unit, input logic [2:0] off);
    case (unit)
      UNIT_B:  lane_be = 8'h01 << off;
      UNIT_HW: lane_be = 8'h03 << off;
      UNIT_W:  lane_be = 8'h0F << off;
      UNIT_DW: lane_be = 8'hFF;
      default: lane_be = 8'h00;
    endcase
  endfunction

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [63:0]       data_q [DEPTH];
  logic [7:0]        be_q   [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic [2:0]        off;
  logic [5:0]        sh;
  logic [7:0]        st_be;
  logic [63:0]       st_data;
  logic              st_known;
  logic              st_misal;
  logic              st_req;
  logic              st_ok;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [7:0]        ld_be;
  logic              hazard;

  assign off    = i_struct.mem_addr[2:0];
  assign sh     = {off, 3'b000};
  assign st_req = i_struct.is_valid && i_struct.mem_wr;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  // Store lane alignment and misalignment detection.
  always_comb begin
    st_be    = lane_be(i_struct.mem_req_unit, off);
    st_data  = '0;
    st_known = 1'b1;
    st_misal = 1'b0;
    case (i_struct.mem_req_unit)
      UNIT_B:  st_data = {56'b0, i_struct.mem_data[7:0]} << sh;
      UNIT_HW: begin
        st_data  = {48'b0, i_struct.mem_data[15:0]} << sh;
        st_misal = off[0];
      end
      UNIT_W:  begin
        st_data  = {32'b0, i_struct.mem_data[31:0]} << sh;
        st_misal = |off[1:0];
      end
      UNIT_DW: begin
        st_data  = i_struct.mem_data;
        st_misal = |off;
      end
      default: st_known = 1'b0;
    endcase
  end

  assign st_ok = st_req && st_known && !st_misal;
  assign pop   = !empty && i_dm_wr_ready;
  assign push  = st_ok && (!full || pop);

  assign o_miss_aligned_error = st_req && st_known && st_misal;
  assign o_stall              = st_ok && full && !pop;
  assign o_struct             = i_struct;

  // Load hazard: any occupied entry in the same doubleword with overlapping bytes.
  always_comb begin
    ld_be  = lane_be(i_struct.mem_req_unit, off);
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (addr_q[i][ADDR_W-1:3] == i_struct.mem_addr[ADDR_W-1:3])
          && |(be_q[i] & ld_be))
        hazard = 1'b1;
    end
  end

  assign o_load_hazard = i_struct.is_valid && i_struct.mem_rd && hazard;

  // Store-buffer storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      // A push into the slot being popped (full buffer) keeps it occupied.
      if (push) begin
        occ[wr_ptr]    <= 1'b1;
        addr_q[wr_ptr] <= {i_struct.mem_addr[ADDR_W-1:3], 3'b000};
        data_q[wr_ptr] <= st_data;
        be_q[wr_ptr]   <= st_be;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_dm_wr_valid = !empty;
  assign o_dm_wr_addr  = empty ? '0 : addr_q[rd_ptr];
  assign o_dm_wr_data  = empty ? '0 : data_q[rd_ptr];
  assign o_dm_wr_be    = empty ? '0 : be_q[rd_ptr];
  assign o_sb_empty    = empty;
  assign o_sb_count    = count;

endmodule

// File: tb/tb_dm_store_controller.sv
// Directed plus short randomized bench for dm_store_controller with an
// expected-write queue checked at every Data Memory handshake.

module tb_dm_store_controller;
  import dm_store_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;

  logic                 clk;
  logic                 rst_n;
  interconnection_struct i_struct;
  interconnection_struct o_struct;
  logic                 o_stall;
  logic                 o_miss_aligned_error;
  logic                 o_load_hazard;
  logic                 o_dm_wr_valid;
  logic                 i_dm_wr_ready;
  logic [ADDR_W-1:0]    o_dm_wr_addr;
  logic [63:0]          o_dm_wr_data;
  logic [7:0]           o_dm_wr_be;
  logic                 o_sb_empty;
  logic [2:0]           o_sb_count;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writes: {addr, data, be}
  logic [135:0] exp_q[$];

  dm_store_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_struct(i_struct),
    .o_struct(o_struct),
    .o_stall(o_stall),
    .o_miss_aligned_error(o_miss_aligned_error),
    .o_load_hazard(o_load_hazard),
    .o_dm_wr_valid(o_dm_wr_valid),
    .i_dm_wr_ready(i_dm_wr_ready),
    .o_dm_wr_addr(o_dm_wr_addr),
    .o_dm_wr_data(o_dm_wr_data),
    .o_dm_wr_be(o_dm_wr_be),
    .o_sb_empty(o_sb_empty),
    .o_sb_count(o_sb_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference lane placement built byte by byte.
  task automatic model_lane(input logic [2:0] unit, input logic [63:0] addr,
                            input logic [63:0] data,
                            output logic [7:0] be, output logic [63:0] d);
    int n;
    int o;
    n  = 1 << unit;
    o  = int'(addr[2:0]);
    be = '0;
    d  = '0;
    for (int k = 0; k < n; k++) begin
      be[o+k]        = 1'b1;
      d[8*(o+k) +: 8] = data[8*k +: 8];
    end
  endtask

  task automatic expect_store(input logic [2:0] unit, input logic [63:0] addr,
                              input logic [63:0] data);
    logic [7:0]  be;
    logic [63:0] d;
    model_lane(unit, addr, data, be, d);
    exp_q.push_back({addr & ~64'h7, d, be});
  endtask

  // Driver tasks
  task automatic set_idle();
    i_struct = '0;
  endtask

  task automatic set_store(input logic [2:0] unit, input logic [63:0] addr, input logic [63:0] data);
    i_struct = '0;
    i_struct.is_valid = 1'b1;
    i_struct.mem_wr = 1'b1;
    i_struct.mem_req_unit = unit;
    i_struct.mem_addr = addr;
    i_struct.mem_data = data;
  endtask

  task automatic set_load(input logic [2:0] unit, input logic [63:0] addr);
    i_struct = '0;
    i_struct.is_valid = 1'b1;
    i_struct.mem_rd = 1'b1;
    i_struct.mem_req_unit = unit;
    i_struct.mem_addr = addr;
    i_struct.mem_data = 64'h0123_4567_89AB_CDEF;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!o_sb_empty && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(o_sb_empty), 64'd1);
    next_cycle();
  endtask

  // Scoreboard: compare each Data Memory handshake against the expected queue.
  always @(negedge clk) begin
    if (rst_n && o_dm_wr_valid && i_dm_wr_ready) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [135:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", o_dm_wr_addr, e[135:72]);
        chk("wr_data", o_dm_wr_data, e[71:8]);
        chk("wr_be", 64'(o_dm_wr_be), 64'(e[7:0]));
      end
    end
  end

  initial begin
    logic [63:0] first_data;
    rst_n = 1'b0;
    i_dm_wr_ready = 1'b0;
    set_idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 64'(o_dm_wr_valid), 64'd0);
    chk("rst_count", 64'(o_sb_count), 64'd0);
    chk("rst_empty", 64'(o_sb_empty), 64'd1);
    chk("rst_addr", o_dm_wr_addr, 64'd0);
    chk("rst_data", o_dm_wr_data, 64'd0);
    chk("rst_be", 64'(o_dm_wr_be), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // W store at 0x1004 with ready high
    i_dm_wr_ready = 1'b1;
    set_store(UNIT_W, 64'h1004, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    chk("w_stall", 64'(o_stall), 64'd0);
    chk("w_err", 64'(o_miss_aligned_error), 64'd0);
    chk("w_not_yet_valid", 64'(o_dm_wr_valid), 64'd0);
    exp_q.push_back({64'h1000, 64'hDEAD_BEEF_0000_0000, 8'hF0});
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("w_valid_next", 64'(o_dm_wr_valid), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("w_empty_after", 64'(o_sb_empty), 64'd1);
    next_cycle();

    // Misaligned HW, then B at the same offset
    set_store(UNIT_HW, 64'h1003, 64'h1234);
    @(negedge clk);
    chk("hw_mis_err", 64'(o_miss_aligned_error), 64'd1);
    chk("hw_mis_stall", 64'(o_stall), 64'd0);
    next_cycle();
    set_store(UNIT_B, 64'h1003, 64'hAB);
    @(negedge clk);
    chk("hw_mis_count", 64'(o_sb_count), 64'd0);
    chk("b_err", 64'(o_miss_aligned_error), 64'd0);
    exp_q.push_back({64'h1000, 64'h0000_0000_AB00_0000, 8'h08});
    next_cycle();
    set_idle();
    wait_empty("b_drain");

    // Unknown unit: no enqueue, no error, no stall
    set_store(3'd6, 64'h1001, 64'hFF);
    @(negedge clk);
    chk("unk_err", 64'(o_miss_aligned_error), 64'd0);
    chk("unk_stall", 64'(o_stall), 64'd0);
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("unk_count", 64'(o_sb_count), 64'd0);
    next_cycle();

    // Fill with ready low, stall on the fifth, release
    i_dm_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(UNIT_DW, 64'(8 * i), 64'hA5A5_0000_0000_0000 + 64'(i));
      @(negedge clk);
      chk("fill_stall", 64'(o_stall), 64'd0);
      expect_store(UNIT_DW, 64'(8 * i), 64'hA5A5_0000_0000_0000 + 64'(i));
      next_cycle();
    end
    set_store(UNIT_DW, 64'h20, 64'hA5A5_0000_0000_0004);
    @(negedge clk);
    chk("full_count", 64'(o_sb_count), 64'd4);
    chk("full_stall", 64'(o_stall), 64'd1);
    chk("head_addr0", o_dm_wr_addr, 64'h0);
    first_data = o_dm_wr_data;
    chk("head_data0", first_data, 64'hA5A5_0000_0000_0000);
    next_cycle();
    @(negedge clk);
    chk("still_stall", 64'(o_stall), 64'd1);
    chk("head_addr_stable", o_dm_wr_addr, 64'h0);
    chk("head_data_stable", o_dm_wr_data, 64'hA5A5_0000_0000_0000);
    chk("valid_held", 64'(o_dm_wr_valid), 64'd1);
    next_cycle();
    i_dm_wr_ready = 1'b1;
    @(negedge clk);
    chk("release_stall", 64'(o_stall), 64'd0);
    expect_store(UNIT_DW, 64'h20, 64'hA5A5_0000_0000_0004);
    next_cycle();
    set_idle();
    i_dm_wr_ready = 1'b0;
    @(negedge clk);
    chk("push_pop_count", 64'(o_sb_count), 64'd4);
    chk("head_addr1", o_dm_wr_addr, 64'h8);
    next_cycle();
    i_dm_wr_ready = 1'b1;
    wait_empty("fill_drain");

    // Load hazard against a buffered byte store
    i_dm_wr_ready = 1'b0;
    set_store(UNIT_B, 64'h2001, 64'h5A);
    @(negedge clk);
    expect_store(UNIT_B, 64'h2001, 64'h5A);
    next_cycle();
    set_load(UNIT_W, 64'h2000);
    @(negedge clk);
    chk("hz_overlap", 64'(o_load_hazard), 64'd1);
    chk("passthrough", o_struct.mem_data, 64'h0123_4567_89AB_CDEF);
    chk("pass_addr", o_struct.mem_addr, 64'h2000);
    next_cycle();
    set_load(UNIT_W, 64'h2004);
    @(negedge clk);
    chk("hz_other_bytes", 64'(o_load_hazard), 64'd0);
    next_cycle();
    set_load(UNIT_DW, 64'h3000);
    @(negedge clk);
    chk("hz_other_dword", 64'(o_load_hazard), 64'd0);
    next_cycle();
    set_load(UNIT_B, 64'h2001);
    i_dm_wr_ready = 1'b1;
    @(negedge clk);
    chk("hz_while_pop", 64'(o_load_hazard), 64'd1);
    next_cycle();
    set_idle();
    wait_empty("hz_drain");

    // Randomized aligned stores with random ready
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  u;
      logic [63:0] a;
      logic [63:0] d;
      int          k;
      u = 3'($urandom_range(0, 3));
      a = {48'h0, 16'($urandom_range(0, 65535))} & ~((64'd1 << u) - 64'd1);
      d = {32'($urandom), 32'($urandom)};
      set_store(u, a, d);
      i_dm_wr_ready = 1'($urandom_range(0, 1));
      k = 0;
      @(negedge clk);
      while (o_stall && k < 20) begin
        next_cycle();
        i_dm_wr_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
      end
      chk("rnd_accept", 64'(o_stall), 64'd0);
      chk("rnd_err", 64'(o_miss_aligned_error), 64'd0);
      expect_store(u, a, d);
      next_cycle();
    end
    set_idle();
    i_dm_wr_ready = 1'b1;
    wait_empty("rnd_drain");

    // Reset mid-drain discards buffered stores
    i_dm_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(UNIT_DW, 64'h4000 + 64'(8 * i), 64'(i) + 64'h77);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    chk("pre_rst_count", 64'(o_sb_count), 64'd3);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(o_dm_wr_valid), 64'd0);
    chk("mid_rst_count", 64'(o_sb_count), 64'd0);
    chk("mid_rst_empty", 64'(o_sb_empty), 64'd1);
    next_cycle();
    i_dm_wr_ready = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("post_rst_no_write", 64'(o_dm_wr_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
